// File: rtl/fwd_pkg.sv
package fwd_pkg;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

  localparam int unsigned ZERO_REG_DEFAULT = 31;

  typedef enum logic {
    ST_RUN,
    ST_STALL
  } state_t;

endpackage

// File: rtl/fwd_sel_lane.sv
module fwd_sel_lane
  import fwd_pkg::*;
#(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ZERO_REG = ZERO_REG_DEFAULT
) (
  input  logic [REG_W-1:0] rs_i,
  input  logic             rs_used_i,
  input  logic [REG_W-1:0] ex_mem_rd_i,
  input  logic             ex_mem_reg_write_i,
  input  logic [REG_W-1:0] mem_wb_rd_i,
  input  logic             mem_wb_reg_write_i,
  output fwd_sel_t         sel_o
);

  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  logic hit_exmem;
  logic hit_memwb;

  always_comb begin
    hit_exmem = rs_used_i && ex_mem_reg_write_i &&
                (ex_mem_rd_i != ZR) && (ex_mem_rd_i == rs_i);
    hit_memwb = rs_used_i && mem_wb_reg_write_i &&
                (mem_wb_rd_i != ZR) && (mem_wb_rd_i == rs_i);
    sel_o = FWD_NONE;
    if (hit_exmem) begin
      sel_o = FWD_EXMEM;
    end else if (hit_memwb) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 3,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ZERO_REG = ZERO_REG_DEFAULT,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*REG_W-1:0] if_id_rs,
  input  logic [NUM_SRC-1:0]       if_id_rs_used,
  input  logic [NUM_SRC*REG_W-1:0] id_ex_rs,
  input  logic [NUM_SRC-1:0]       id_ex_rs_used,
  input  logic [REG_W-1:0]         id_ex_rd,
  input  logic                     id_ex_mem_read,
  input  logic [REG_W-1:0]         ex_mem_rd,
  input  logic                     ex_mem_reg_write,
  input  logic [REG_W-1:0]         mem_wb_rd,
  input  logic                     mem_wb_reg_write,
  input  logic                     flush,
  output logic [NUM_SRC*2-1:0]     fwd_sel,
  output logic                     pc_write_en,
  output logic                     if_id_write_en,
  output logic                     id_ex_bubble,
  output logic [CNT_W-1:0]         stall_cycles
);

  localparam logic [REG_W-1:0] ZR       = REG_W'(ZERO_REG);
  localparam logic [2:0]       CNT_LOAD = 3'(LOAD_LAT - 1);

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
    fwd_sel_t sel;
    fwd_sel_lane #(
      .REG_W    (REG_W),
      .ZERO_REG (ZERO_REG)
    ) u_lane (
      .rs_i               (id_ex_rs[g*REG_W +: REG_W]),
      .rs_used_i          (id_ex_rs_used[g]),
      .ex_mem_rd_i        (ex_mem_rd),
      .ex_mem_reg_write_i (ex_mem_reg_write),
      .mem_wb_rd_i        (mem_wb_rd),
      .mem_wb_reg_write_i (mem_wb_reg_write),
      .sel_o              (sel)
    );
    assign fwd_sel[g*2 +: 2] = sel;
  end

  logic             src_match;
  logic             haz;
  logic             stall;
  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q;

  always_comb begin
    src_match = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (if_id_rs_used[i] && (if_id_rs[i*REG_W +: REG_W] == id_ex_rd)) begin
        src_match = 1'b1;
      end
    end
    haz = id_ex_mem_read && (id_ex_rd != ZR) && src_match;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The first stall cycle is taken combinationally in RUN; STALL only covers
  // the remaining LOAD_LAT-1 cycles, so a single-cycle latency never leaves RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (haz && !flush && (LOAD_LAT > 1)) begin
          state_d = ST_STALL;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_STALL: begin
        if (flush) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall = 1'b0;
    unique case (state_q)
      ST_RUN:   stall = haz && !flush;
      ST_STALL: stall = !flush;
      default:  stall = 1'b0;
    endcase
    pc_write_en    = !stall;
    if_id_write_en = !stall;
    id_ex_bubble   = stall || flush;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
    end else if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  localparam int unsigned NS = 3;
  localparam int unsigned RW = 5;
  localparam int unsigned NI = 3;

  logic            clk;
  logic            reset;
  logic [NS*RW-1:0] if_id_rs;
  logic [NS-1:0]    if_id_rs_used;
  logic [NS*RW-1:0] id_ex_rs;
  logic [NS-1:0]    id_ex_rs_used;
  logic [RW-1:0]    id_ex_rd;
  logic             id_ex_mem_read;
  logic [RW-1:0]    ex_mem_rd;
  logic             ex_mem_reg_write;
  logic [RW-1:0]    mem_wb_rd;
  logic             mem_wb_reg_write;
  logic             flush;

  logic [NS*2-1:0] fwd_a, fwd_b, fwd_c;
  logic            pcw_a, pcw_b, pcw_c;
  logic            ifw_a, ifw_b, ifw_c;
  logic            bub_a, bub_b, bub_c;
  logic [15:0]     scnt_a, scnt_b;
  logic [3:0]      scnt_c;

  fwd_hazard_unit #(.NUM_SRC(NS), .REG_W(RW), .ZERO_REG(31), .LOAD_LAT(1), .CNT_W(16)) u_dut_l1 (
    .clk(clk), .reset(reset), .if_id_rs(if_id_rs), .if_id_rs_used(if_id_rs_used),
    .id_ex_rs(id_ex_rs), .id_ex_rs_used(id_ex_rs_used), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read(id_ex_mem_read), .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write), .flush(flush),
    .fwd_sel(fwd_a), .pc_write_en(pcw_a), .if_id_write_en(ifw_a), .id_ex_bubble(bub_a),
    .stall_cycles(scnt_a));

  fwd_hazard_unit #(.NUM_SRC(NS), .REG_W(RW), .ZERO_REG(31), .LOAD_LAT(3), .CNT_W(16)) u_dut_l3 (
    .clk(clk), .reset(reset), .if_id_rs(if_id_rs), .if_id_rs_used(if_id_rs_used),
    .id_ex_rs(id_ex_rs), .id_ex_rs_used(id_ex_rs_used), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read(id_ex_mem_read), .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write), .flush(flush),
    .fwd_sel(fwd_b), .pc_write_en(pcw_b), .if_id_write_en(ifw_b), .id_ex_bubble(bub_b),
    .stall_cycles(scnt_b));

  fwd_hazard_unit #(.NUM_SRC(NS), .REG_W(RW), .ZERO_REG(31), .LOAD_LAT(2), .CNT_W(4)) u_dut_sat (
    .clk(clk), .reset(reset), .if_id_rs(if_id_rs), .if_id_rs_used(if_id_rs_used),
    .id_ex_rs(id_ex_rs), .id_ex_rs_used(id_ex_rs_used), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read(id_ex_mem_read), .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write), .flush(flush),
    .fwd_sel(fwd_c), .pc_write_en(pcw_c), .if_id_write_en(ifw_c), .id_ex_bubble(bub_c),
    .stall_cycles(scnt_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: remaining extension cycles and stall totals per instance.
  int lat  [NI] = '{1, 3, 2};
  int smax [NI] = '{65535, 65535, 15};
  int rem  [NI];
  int stot [NI];
  bit exp_stall [NI];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NS*2-1:0] ref_fwd();
    logic [NS*2-1:0] r;
    logic [RW-1:0]   rs;
    r = '0;
    for (int i = 0; i < NS; i++) begin
      rs = id_ex_rs[i*RW +: RW];
      if (id_ex_rs_used[i] && ex_mem_reg_write && ex_mem_rd != 31 && ex_mem_rd == rs)
        r[i*2 +: 2] = 2'b10;
      else if (id_ex_rs_used[i] && mem_wb_reg_write && mem_wb_rd != 31 && mem_wb_rd == rs)
        r[i*2 +: 2] = 2'b01;
    end
    return r;
  endfunction

  function automatic bit ref_haz();
    bit m;
    m = 0;
    for (int i = 0; i < NS; i++)
      if (if_id_rs_used[i] && if_id_rs[i*RW +: RW] == id_ex_rd) m = 1;
    return id_ex_mem_read && id_ex_rd != 31 && m;
  endfunction

  task automatic check_all();
    logic [NS*2-1:0] ef;
    bit h;
    ef = ref_fwd();
    h  = ref_haz();
    for (int k = 0; k < NI; k++)
      exp_stall[k] = (rem[k] > 0) ? !flush : (h && !flush);
    chk("fwd_l1", 32'(fwd_a), 32'(ef));
    chk("fwd_l3", 32'(fwd_b), 32'(ef));
    chk("fwd_sat", 32'(fwd_c), 32'(ef));
    chk("pcw_l1", 32'(pcw_a), 32'(!exp_stall[0]));
    chk("pcw_l3", 32'(pcw_b), 32'(!exp_stall[1]));
    chk("pcw_sat", 32'(pcw_c), 32'(!exp_stall[2]));
    chk("ifw_l1", 32'(ifw_a), 32'(!exp_stall[0]));
    chk("ifw_l3", 32'(ifw_b), 32'(!exp_stall[1]));
    chk("ifw_sat", 32'(ifw_c), 32'(!exp_stall[2]));
    chk("bub_l1", 32'(bub_a), 32'(exp_stall[0] || flush));
    chk("bub_l3", 32'(bub_b), 32'(exp_stall[1] || flush));
    chk("bub_sat", 32'(bub_c), 32'(exp_stall[2] || flush));
    chk("scnt_l1", 32'(scnt_a), 32'(stot[0]));
    chk("scnt_l3", 32'(scnt_b), 32'(stot[1]));
    chk("scnt_sat", 32'(scnt_c), 32'(stot[2]));
  endtask

  task automatic update_models();
    for (int k = 0; k < NI; k++) begin
      if (rem[k] > 0) rem[k] = flush ? 0 : rem[k] - 1;
      else if (exp_stall[k]) rem[k] = lat[k] - 1;
      if (exp_stall[k] && stot[k] < smax[k]) stot[k]++;
    end
  endtask

  task automatic clear_models();
    for (int k = 0; k < NI; k++) begin
      rem[k]  = 0;
      stot[k] = 0;
    end
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    if (reset) update_models();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_id_rs = '0; if_id_rs_used = '0; id_ex_rs = '0; id_ex_rs_used = '0;
    id_ex_rd = '0; id_ex_mem_read = 0; ex_mem_rd = '0; ex_mem_reg_write = 0;
    mem_wb_rd = '0; mem_wb_reg_write = 0; flush = 0;
  endtask

  task automatic reset_pulse();
    reset = 0;
    clear_models();
    @(posedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  task automatic set_load_use();
    idle_inputs();
    id_ex_mem_read = 1;
    id_ex_rd       = 5'd4;
    if_id_rs       = {5'd0, 5'd4, 5'd1};
    if_id_rs_used  = 3'b010;
  endtask

  function automatic logic [RW-1:0] rnd_reg();
    int unsigned v;
    v = $urandom_range(0, 6);
    return (v == 6) ? 5'd31 : RW'(v);
  endfunction

  initial begin
    clear_models();
    idle_inputs();
    reset = 0;
    #2;
    check_all();
    @(negedge clk);
    reset = 1;

    // Forwarding priority
    ex_mem_rd = 5'd3; mem_wb_rd = 5'd3; ex_mem_reg_write = 1; mem_wb_reg_write = 1;
    id_ex_rs = {5'd0, 5'd0, 5'd3}; id_ex_rs_used = 3'b001;
    #1 chk("prio_exmem", 32'(fwd_a[1:0]), 32'd2);
    ex_mem_reg_write = 0;
    #1 chk("prio_memwb", 32'(fwd_a[1:0]), 32'd1);
    tick();

    // Independent lanes
    idle_inputs();
    ex_mem_rd = 5'd2; mem_wb_rd = 5'd5; ex_mem_reg_write = 1; mem_wb_reg_write = 1;
    id_ex_rs = {5'd9, 5'd5, 5'd2}; id_ex_rs_used = 3'b111;
    #1 chk("lanes_mix", 32'(fwd_b), 32'b00_01_10);
    mem_wb_rd = 5'd31; id_ex_rs[RW +: RW] = 5'd31;
    #1 chk("lane1_zero", 32'(fwd_b[3:2]), 32'd0);
    tick();

    // Load-use: LAT=1 one cycle, LAT=3 three cycles
    reset_pulse();
    set_load_use();
    #1 chk("lu_pcw_first", 32'(pcw_a), 32'd0);
    chk("lu_bub_first", 32'(bub_a), 32'd1);
    tick();
    id_ex_mem_read = 0;
    tick();
    chk("lu1_done", 32'(pcw_a), 32'd1);
    chk("lu1_cnt", 32'(scnt_a), 32'd1);
    chk("lu3_still", 32'(pcw_b), 32'd0);
    tick();
    chk("lu3_run", 32'(pcw_b), 32'd1);
    chk("lu3_cnt", 32'(scnt_b), 32'd3);
    tick();

    // Flush in the second stall cycle
    reset_pulse();
    set_load_use();
    tick();
    id_ex_mem_read = 0; flush = 1;
    #1 chk("fl_pcw", 32'(pcw_b), 32'd1);
    chk("fl_bub", 32'(bub_b), 32'd1);
    tick();
    flush = 0;
    #1 chk("fl_run", 32'(pcw_b), 32'd1);
    chk("fl_cnt", 32'(scnt_b), 32'd1);
    tick();

    // Reset during STALL
    reset_pulse();
    set_load_use();
    tick();
    id_ex_mem_read = 0;
    tick();
    #2;
    reset = 0;
    clear_models();
    #1 chk("rst_pcw", 32'(pcw_b), 32'd1);
    chk("rst_cnt", 32'(scnt_b), 32'd0);
    @(negedge clk);
    reset = 1;
    tick();

    // Saturation with CNT_W=4
    reset_pulse();
    set_load_use();
    for (int c = 0; c < 20; c++) tick();
    chk("sat_cnt", 32'(scnt_c), 32'd15);
    chk("sat_l1_cnt", 32'(scnt_a), 32'd20);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NS; i++) begin
        if_id_rs[i*RW +: RW] = rnd_reg();
        id_ex_rs[i*RW +: RW] = rnd_reg();
      end
      if_id_rs_used    = NS'($urandom);
      id_ex_rs_used    = NS'($urandom);
      id_ex_rd         = rnd_reg();
      id_ex_mem_read   = ($urandom_range(0, 2) == 0);
      ex_mem_rd        = rnd_reg();
      ex_mem_reg_write = 1'($urandom);
      mem_wb_rd        = rnd_reg();
      mem_wb_reg_write = 1'($urandom);
      flush            = ($urandom_range(0, 7) == 0);
      if (c % 97 == 96) reset_pulse();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the 5-stage ARM pipeline.
- Generates per-operand forwarding selects for any number of source operands (Rn, Rm, and store-data Rd for STUR).
- Adds load-use hazard detection with a configurable stall length, honours branch flush, and keeps a saturating stall-cycle counter.
- Sits beside the ID/EX register; drives the EX operand muxes, PC write enable, IF/ID write enable and the ID/EX bubble.

Parameters:
- NUM_SRC, 3, source operands checked per instruction (1..4).
- REG_W, 5, register index width.
- ZERO_REG, 31, index of the hardwired zero register; never forwarded, never causes a stall.
- LOAD_LAT, 1, stall cycles inserted per load-use hazard (1..7).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_id_rs  in  NUM_SRC*REG_W  source indices of the instruction in decode; operand i is bits [i*REG_W +: REG_W].
- if_id_rs_used  in  NUM_SRC  bit i=1 when decode operand i is read.
- id_ex_rs  in  NUM_SRC*REG_W  source indices of the instruction in execute.
- id_ex_rs_used  in  NUM_SRC  bit i=1 when execute operand i is read.
- id_ex_rd  in  REG_W  destination of the instruction in execute.
- id_ex_mem_read  in  1  the instruction in execute is a load.
- ex_mem_rd  in  REG_W  destination held in EX/MEM.
- ex_mem_reg_write  in  1  EX/MEM instruction writes the register file.
- mem_wb_rd  in  REG_W  destination held in MEM/WB.
- mem_wb_reg_write  in  1  MEM/WB instruction writes the register file.
- flush  in  1  taken branch; squashes the instructions in decode and fetch this cycle.
- fwd_sel  out  NUM_SRC*2  per-operand select: 00 register file, 01 MEM/WB, 10 EX/MEM; 11 is never driven.
- pc_write_en  out  1  0 holds the PC.
- if_id_write_en  out  1  0 holds IF/ID.
- id_ex_bubble  out  1  1 zeroes the ID/EX control fields.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- fwd_sel is combinational and evaluated independently per operand i.
  - 10 if id_ex_rs_used[i], ex_mem_reg_write, ex_mem_rd != ZERO_REG and ex_mem_rd == rs_i.
  - Otherwise 01 if id_ex_rs_used[i], mem_wb_reg_write, mem_wb_rd != ZERO_REG and mem_wb_rd == rs_i.
  - Otherwise 00.
  - EX/MEM always takes priority over MEM/WB. Several operands may forward at once.
- Hazard term (combinational): haz = id_ex_mem_read and id_ex_rd != ZERO_REG and, for some i, if_id_rs_used[i] with if_id_rs_i == id_ex_rd.
- FSM states: RUN and STALL; a 3-bit counter cnt.
- RUN:
  - stall = haz and not flush.
  - If stall and LOAD_LAT > 1: next state STALL, cnt <= LOAD_LAT-1.
  - If stall and LOAD_LAT = 1: stay in RUN.
- STALL:
  - stall = not flush; hazard detection is not re-evaluated.
  - cnt decrements each cycle; when cnt == 1, next state is RUN.
  - flush forces RUN with cnt <= 0 on the next edge.
- Outputs:
  - pc_write_en = if_id_write_en = not stall.
  - id_ex_bubble = stall or flush.
- Flush and hazard in the same cycle: flush wins, so there is no stall and the bubble is asserted.
- stall_cycles increments on every cycle in which stall = 1 and saturates at all-ones; it does not wrap.
- Reset (asynchronous, active-low):
  - state RUN, cnt 0, stall_cycles 0.
  - Combinational outputs follow their inputs; with idle inputs this gives fwd_sel 0, pc_write_en 1, if_id_write_en 1, id_ex_bubble 0.
- Reset asserted mid-stall aborts the stall immediately.
- Latency: forwarding and first-cycle stall are zero-cycle (combinational); the FSM only extends stalls.

Decomposition:
- Package fwd_pkg holds:
  - fwd_sel_t enum: FWD_NONE=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10.
  - The ZERO_REG default.
  - The state enum: ST_RUN, ST_STALL.
- One sub-module, fwd_sel_lane: the per-operand compare and priority logic, instantiated NUM_SRC times in a generate loop.
- FSM, counter and stall logic live in the top module.

Test Plan:
- Forwarding priority: ex_mem_rd=3 and mem_wb_rd=3, both writing, id_ex_rs0=3 -> fwd_sel[1:0]=10. Disable ex_mem_reg_write -> 01.
- Independent operands: ex_mem_rd=2, mem_wb_rd=5, id_ex_rs={x,5,2}, all used -> fwd_sel lane0=10, lane1=01, lane2=00. Set mem_wb_rd=31 with id_ex_rs1=31 -> lane1=00.
- Load-use with LOAD_LAT=1: id_ex_mem_read=1, id_ex_rd=4, if_id_rs1=4 used -> one cycle with pc_write_en=0, if_id_write_en=0, id_ex_bubble=1; stall_cycles=1.
- Load-use with LOAD_LAT=3: same stimulus, id_ex_mem_read dropped after the first cycle -> stall held for exactly 3 cycles, then RUN; stall_cycles=3.
- Flush mid-stall with LOAD_LAT=3: flush asserted in the 2nd stall cycle -> that cycle pc_write_en=1 and id_ex_bubble=1; RUN on the next edge; stall_cycles=1.
- Reset and saturation: pull reset low during STALL -> stall deasserts asynchronously and stall_cycles=0. With CNT_W=4, hold a hazard for 20 stalls -> stall_cycles=15 and no wrap.
